// File: rtl/exs_of_operand_loader_if.sv
// Stream and frame-output bundle for exs_of_operand_loader.
// slave  : loader side (consumes the beat stream, produces the operand frame)
// master : feeder/consumer side (drives the beat stream, observes the operand frame)
interface exs_of_operand_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                         s_valid_i;
  logic signed [DATA_WIDTH-1:0] s_data_i;
  logic                         s_last_i;
  logic                         s_ready_o;
  logic                         valid_o;
  logic signed [DATA_WIDTH-1:0] a_o;
  logic signed [DATA_WIDTH-1:0] b_o;
  logic signed [DATA_WIDTH-1:0] c_o;
  logic signed [DATA_WIDTH-1:0] d_o;
  logic                         frame_err_o;
  logic                         timeout_o;
  logic [15:0]                  frame_cnt_o;

  modport slave (
    input  s_valid_i, s_data_i, s_last_i,
    output s_ready_o, valid_o, a_o, b_o, c_o, d_o, frame_err_o, timeout_o, frame_cnt_o
  );

  modport master (
    output s_valid_i, s_data_i, s_last_i,
    input  s_ready_o, valid_o, a_o, b_o, c_o, d_o, frame_err_o, timeout_o, frame_cnt_o
  );
endinterface

// File: rtl/exs_of_operand_loader.sv
// exs_of_operand_loader: collects operands a,b,c,d one word per beat from a valid/ready
// stream (d tagged with s_last_i) and issues them in parallel with a one-cycle valid_o.
// Malformed frames are dropped with a frame_err_o pulse so exs_of only sees whole sets.
// Optional feature macro: EXS_LOADER_TIMEOUT_EN -- abandons a partial frame after
// TIMEOUT_CYCLES idle cycles in LOAD_B/C/D and pulses timeout_o. Without it, timeout_o
// is tied low and partial frames wait indefinitely.
module exs_of_operand_loader #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  exs_of_operand_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    LOAD_C = 3'd3,
    LOAD_D = 3'd4,
    ISSUE  = 3'd5,
    DRAIN  = 3'd6
  } state_t;

  state_t state;
  state_t state_nxt;

  logic accept;
  logic ld_a;
  logic ld_b;
  logic ld_c;
  logic vld_p0;
  logic err_p0;
  logic to_p0;
  logic to_hit;
  logic ready_nxt;

  logic signed [DATA_WIDTH-1:0] a_p0;
  logic signed [DATA_WIDTH-1:0] b_p0;
  logic signed [DATA_WIDTH-1:0] c_p0;

  // A beat transfers only when the registered ready is high; ready never looks at valid.
  assign accept = bus.s_valid_i && bus.s_ready_o;

`ifdef EXS_LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            mid_frame;

  assign mid_frame = (state == LOAD_B) || (state == LOAD_C) || (state == LOAD_D);
  // The last tolerated idle cycle is the one where the count already shows TIMEOUT_CYCLES-1.
  assign to_hit    = mid_frame && !accept && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Idle-cycle counter: cleared by any accepted beat, outside a partial frame, and on return to LOAD_A.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt <= '0;
    end else if (accept || !mid_frame || (state_nxt == LOAD_A)) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;

  assign to_hit             = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // State register; reset parks in IDLE so ready stays low until the first edge after release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus one-cycle strobes and staging load enables.
  always_comb begin
    state_nxt = state;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_c      = 1'b0;
    vld_p0    = 1'b0;
    err_p0    = 1'b0;
    to_p0     = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = LOAD_A;
      end
      LOAD_A: begin
        if (accept) begin
          if (bus.s_last_i) begin
            err_p0    = 1'b1;
            state_nxt = LOAD_A;
          end else begin
            ld_a      = 1'b1;
            state_nxt = LOAD_B;
          end
        end
      end
      LOAD_B: begin
        if (accept) begin
          if (bus.s_last_i) begin
            err_p0    = 1'b1;
            state_nxt = LOAD_A;
          end else begin
            ld_b      = 1'b1;
            state_nxt = LOAD_C;
          end
        end
      end
      LOAD_C: begin
        if (accept) begin
          if (bus.s_last_i) begin
            err_p0    = 1'b1;
            state_nxt = LOAD_A;
          end else begin
            ld_c      = 1'b1;
            state_nxt = LOAD_D;
          end
        end
      end
      LOAD_D: begin
        if (accept) begin
          if (bus.s_last_i) begin
            vld_p0    = 1'b1;
            state_nxt = ISSUE;
          end else begin
            // An overlong frame: swallow the rest of it up to its last beat.
            err_p0    = 1'b1;
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (accept && bus.s_last_i) begin
          state_nxt = LOAD_A;
        end
      end
      ISSUE: begin
        state_nxt = LOAD_A;
      end
      default: begin
        state_nxt = LOAD_A;
      end
    endcase
    // Timeout only fires on a cycle without an accepted beat, so it never races an error.
    if (to_hit) begin
      state_nxt = LOAD_A;
      to_p0     = 1'b1;
    end
  end

  assign ready_nxt = (state_nxt != ISSUE) && (state_nxt != IDLE);

  // Staging for a, b, c; d bypasses staging straight into d_o on the issuing edge.
  always_ff @(posedge clk_i) begin
    if (ld_a) a_p0 <= bus.s_data_i;
    if (ld_b) b_p0 <= bus.s_data_i;
    if (ld_c) c_p0 <= bus.s_data_i;
  end

  // ---- stage p0 -> registered outputs ----
  // Registered outputs: operands load only on the edge that enters ISSUE and hold afterwards.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.s_ready_o   <= 1'b0;
      bus.valid_o     <= 1'b0;
      bus.frame_err_o <= 1'b0;
      bus.timeout_o   <= 1'b0;
      bus.frame_cnt_o <= 16'd0;
      bus.a_o         <= '0;
      bus.b_o         <= '0;
      bus.c_o         <= '0;
      bus.d_o         <= '0;
    end else begin
      bus.s_ready_o   <= ready_nxt;
      bus.valid_o     <= vld_p0;
      bus.frame_err_o <= err_p0;
      bus.timeout_o   <= to_p0;
      if (vld_p0) begin
        bus.a_o         <= a_p0;
        bus.b_o         <= b_p0;
        bus.c_o         <= c_p0;
        bus.d_o         <= bus.s_data_i;
        bus.frame_cnt_o <= bus.frame_cnt_o + 16'd1;
      end
    end
  end

endmodule
